p1_hazard_ctrl: RTL and testbench

//  Pipeline hazard sequencer for the P1 core: drives stall/flush of the IF/ID register, PC hold,
//  ID/EX bubble insertion and back-end freeze. Detects load-use hazards, taken-branch flushes
//  and multi-cycle data-memory waits; sequences multi-cycle stalls with a small FSM.

---
 rtl/p1_hazard_ctrl.sv | 118 +++++++++++
 tb/tb_p1_hazard_ctrl.sv | 113 +++++++++++
 2 files changed

// File: rtl/p1_hazard_ctrl.sv
// p1_hazard_ctrl: P1 pipeline hazard sequencer (load-use stall, branch flush, memory-wait freeze).
// Define HAZ_PERF_CNT_EN to build the saturating stall/flush performance counters.
module p1_hazard_ctrl #(
  parameter int LOAD_STALL_CYCLES = 2,
  parameter int FLUSH_CYCLES      = 1,
  parameter int MEM_TIMEOUT       = 15,
  parameter int CNT_W             = 16
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic [4:0]       i_id_rs1,
  input  logic [4:0]       i_id_rs2,
  input  logic             i_id_rs1_used,
  input  logic             i_id_rs2_used,
  input  logic [2:0]       i_id_type,
  input  logic             i_ex_valid,
  input  logic             i_ex_is_load,
  input  logic [4:0]       i_ex_rd,
  input  logic             i_branch_taken,
  input  logic             i_mem_busy,
  output logic             o_stall_pc,
  output logic             o_stall_ifid,
  output logic             o_flush_ifid,
  output logic             o_bubble_idex,
  output logic             o_freeze_back,
  output logic             o_mem_err,
  output logic [CNT_W-1:0] o_stall_cycles,
  output logic [CNT_W-1:0] o_flush_count
);
  typedef enum logic [1:0] {RUN, LOAD_STALL, FLUSH, MEM_WAIT} state_t;
  localparam logic [3:0] L_RELOAD = 4'(LOAD_STALL_CYCLES - 1);
  localparam logic [3:0] F_RELOAD = 4'(FLUSH_CYCLES - 1);
  state_t r_state, w_state_n, r_ret, w_ret_n, w_eff;
  logic [3:0] r_cnt, w_cnt_n;
  logic [7:0] r_tmo, w_tmo_n;
  logic r_pend, w_pend_n, r_mem_err;
  logic w_hazard, w_br;
  assign w_hazard = i_ex_valid & i_ex_is_load & (i_ex_rd != 5'd0) & (i_id_type != 3'd7) &
                    ((i_id_rs1_used & (i_id_rs1 == i_ex_rd)) | (i_id_rs2_used & (i_id_rs2 == i_ex_rd)));
  // Leaving MEM_WAIT resumes whichever sequence was interrupted, with a deferred flush acting as a branch.
  assign w_eff = (r_state == MEM_WAIT) ? r_ret : r_state;
  assign w_br  = i_branch_taken | ((r_state == MEM_WAIT) & r_pend);
  always_comb begin
    o_stall_pc    = 1'b0;
    o_stall_ifid  = 1'b0;
    o_flush_ifid  = 1'b0;
    o_bubble_idex = 1'b0;
    o_freeze_back = 1'b0;
    w_state_n     = RUN;
    w_ret_n       = r_ret;
    w_cnt_n       = r_cnt;
    w_pend_n      = r_pend;
    w_tmo_n       = 8'd0;
    if (i_mem_busy) begin
      {o_stall_pc, o_stall_ifid, o_freeze_back} = 3'b111;
      w_state_n = MEM_WAIT;
      w_ret_n   = w_eff;
      w_pend_n  = r_pend | i_branch_taken;
      w_tmo_n   = (r_tmo == 8'hFF) ? r_tmo : r_tmo + 8'd1;
    end else if (w_br) begin
      {o_flush_ifid, o_bubble_idex} = 2'b11;
      w_pend_n  = 1'b0;
      w_cnt_n   = F_RELOAD;
      w_state_n = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
    end else if (w_eff == LOAD_STALL) begin
      {o_stall_pc, o_stall_ifid, o_bubble_idex} = 3'b111;
      w_cnt_n   = r_cnt - 4'd1;
      w_state_n = (r_cnt == 4'd1) ? RUN : LOAD_STALL;
    end else if (w_eff == FLUSH) begin
      {o_flush_ifid, o_bubble_idex} = 2'b11;
      w_cnt_n   = r_cnt - 4'd1;
      w_state_n = (r_cnt == 4'd1) ? RUN : FLUSH;
    end else if (w_hazard) begin
      {o_stall_pc, o_stall_ifid, o_bubble_idex} = 3'b111;
      w_cnt_n   = L_RELOAD;
      w_state_n = (LOAD_STALL_CYCLES > 1) ? LOAD_STALL : RUN;
    end
    if (!i_reset_n) begin
      {o_stall_pc, o_stall_ifid, o_freeze_back} = 3'b000;
      {o_flush_ifid, o_bubble_idex} = 2'b11;
    end
  end
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_state   <= RUN;
      r_ret     <= RUN;
      r_cnt     <= 4'd0;
      r_tmo     <= 8'd0;
      r_pend    <= 1'b0;
      r_mem_err <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_ret   <= w_ret_n;
      r_cnt   <= w_cnt_n;
      r_tmo   <= w_tmo_n;
      r_pend  <= w_pend_n;
      if (i_mem_busy && w_tmo_n >= 8'(MEM_TIMEOUT)) r_mem_err <= 1'b1;
    end
  end
  assign o_mem_err = r_mem_err;
`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] r_sc, r_fc;
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_sc <= '0;
      r_fc <= '0;
    end else begin
      if (o_stall_pc && !(&r_sc)) r_sc <= r_sc + CNT_W'(1);
      if (!i_mem_busy && w_br && !(&r_fc)) r_fc <= r_fc + CNT_W'(1);
    end
  end
  assign o_stall_cycles = r_sc;
  assign o_flush_count  = r_fc;
`else
  assign o_stall_cycles = '0;
  assign o_flush_count  = '0;
`endif
endmodule

// File: tb/tb_p1_hazard_ctrl.sv
// tb_p1_hazard_ctrl: directed vectors for p1_hazard_ctrl; driver queues expectations, negedge monitor checks them.
module tb_p1_hazard_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [4:0] rs1 = '0, rs2 = '0, ex_rd = '0;
  logic u1 = 0, u2 = 0, ex_v = 0, ex_ld = 0, br = 0, mb = 0;
  logic [2:0] ty = '0;
  logic spc, sifid, fl, bub, frz, err;
  logic [15:0] sc, fc;
  typedef struct {logic [4:0] ctrl; logic err; logic [15:0] sc; logic [15:0] fc;} exp_t;
  exp_t q[$];
  exp_t e;
  int n_chk = 0, n_fail = 0;

  p1_hazard_ctrl dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_id_rs1(rs1), .i_id_rs2(rs2),
    .i_id_rs1_used(u1), .i_id_rs2_used(u2), .i_id_type(ty), .i_ex_valid(ex_v),
    .i_ex_is_load(ex_ld), .i_ex_rd(ex_rd), .i_branch_taken(br), .i_mem_busy(mb),
    .o_stall_pc(spc), .o_stall_ifid(sifid), .o_flush_ifid(fl), .o_bubble_idex(bub),
    .o_freeze_back(frz), .o_mem_err(err), .o_stall_cycles(sc), .o_flush_count(fc)
  );

  always #5 clk = ~clk;

  task automatic cyc(input logic rn, input logic [4:0] r1, input logic [4:0] r2, input logic a1,
                     input logic a2, input logic [2:0] t, input logic v, input logic ld,
                     input logic [4:0] rd, input logic b, input logic m, input logic [4:0] ctrl,
                     input logic er, input int esc, input int efc);
    exp_t x;
    @(posedge clk);
    #1;
    rst_n = rn; rs1 = r1; rs2 = r2; u1 = a1; u2 = a2; ty = t;
    ex_v = v; ex_ld = ld; ex_rd = rd; br = b; mb = m;
`ifndef HAZ_PERF_CNT_EN
    esc = 0;
    efc = 0;
`endif
    x.ctrl = ctrl; x.err = er; x.sc = 16'(esc); x.fc = 16'(efc);
    q.push_back(x);
  endtask

  task automatic idle(input logic b, input logic m, input logic [4:0] ctrl, input logic er,
                      input int esc, input int efc);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, b, m, ctrl, er, esc, efc);
  endtask

  // ctrl = {stall_pc, stall_ifid, flush_ifid, bubble_idex, freeze_back}
  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      n_chk += 3;
      if ({spc, sifid, fl, bub, frz} !== e.ctrl) begin
        n_fail++;
        $display("FAIL ctrl t=%0t got=%b exp=%b", $time, {spc, sifid, fl, bub, frz}, e.ctrl);
      end
      if (err !== e.err) begin
        n_fail++;
        $display("FAIL mem_err t=%0t got=%b exp=%b", $time, err, e.err);
      end
      if (sc !== e.sc || fc !== e.fc) begin
        n_fail++;
        $display("FAIL counters t=%0t got sc=%0d fc=%0d exp sc=%0d fc=%0d", $time, sc, fc, e.sc, e.fc);
      end
    end
  end

  initial begin
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00110, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00110, 0, 0, 0);
    // load-use on rs1: two stall cycles then clear
    cyc(1, 5, 0, 1, 0, 0, 1, 1, 5, 0, 0, 5'b11010, 0, 0, 0);
    cyc(1, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 5'b11010, 0, 1, 0);
    idle(0, 0, 5'b00000, 0, 2, 0);
    // no hazard: x0 dest, invalid type, unused rs2
    cyc(1, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 5'b00000, 0, 2, 0);
    cyc(1, 0, 5, 0, 1, 7, 1, 1, 5, 0, 0, 5'b00000, 0, 2, 0);
    cyc(1, 3, 5, 1, 0, 0, 1, 1, 5, 0, 0, 5'b00000, 0, 2, 0);
    // single-cycle branch flush
    idle(1, 0, 5'b00110, 0, 2, 0);
    idle(0, 0, 5'b00000, 0, 2, 1);
    // hazard then branch aborts the stall
    cyc(1, 0, 7, 0, 1, 0, 1, 1, 7, 0, 0, 5'b11010, 0, 2, 1);
    cyc(1, 0, 7, 0, 1, 0, 0, 0, 0, 1, 0, 5'b00110, 0, 3, 1);
    idle(0, 0, 5'b00000, 0, 3, 2);
    // 20 busy cycles with branch at entry; timeout visible from busy cycle 16
    idle(1, 1, 5'b11001, 0, 3, 2);
    for (int k = 2; k <= 20; k++) idle(0, 1, 5'b11001, (k >= 16), 3 + k - 1, 2);
    idle(0, 0, 5'b00110, 1, 23, 2);
    idle(0, 0, 5'b00000, 1, 23, 3);
    // memory wait inside a load stall resumes the remaining stall
    cyc(1, 9, 0, 1, 0, 0, 1, 1, 9, 0, 0, 5'b11010, 1, 23, 3);
    idle(0, 1, 5'b11001, 1, 24, 3);
    idle(0, 1, 5'b11001, 1, 25, 3);
    idle(0, 0, 5'b11010, 1, 26, 3);
    idle(0, 0, 5'b00000, 1, 27, 3);
    // reset during load stall
    cyc(1, 4, 0, 1, 0, 0, 1, 1, 4, 0, 0, 5'b11010, 1, 27, 3);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00110, 1, 28, 3);
    idle(0, 0, 5'b00000, 0, 0, 0);
    idle(0, 0, 5'b00000, 0, 0, 0);
    // branch beats a simultaneous hazard
    cyc(1, 6, 0, 1, 0, 0, 1, 1, 6, 1, 0, 5'b00110, 0, 0, 0);
    idle(0, 0, 5'b00000, 0, 0, 1);
    repeat (2) @(negedge clk);
    #1;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got=%0d pending exp=0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
